// File: rtl/hazard_scoreboard.sv
// Hazard/stall unit for the pipelined MIPS core, sitting beside the decoder in D.
// Tracks each in-flight destination register and its remaining Tnew through the
// post-D stages, and checks them against the Tuse of the D-stage sources. It also
// owns the multi-cycle MDU busy counter, so HI/LO accesses can be stalled here.
module hazard_scoreboard #(
  parameter int NSTAGE   = 3,
  parameter int TNEW_W   = 3,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int FSEL_W   = $clog2(NSTAGE + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        d_rs,
  input  logic [4:0]        d_rt,
  input  logic [TNEW_W-1:0] d_tuse_rs,
  input  logic [TNEW_W-1:0] d_tuse_rt,
  input  logic [4:0]        d_wr_addr,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic              d_md_start,
  input  logic              d_md_is_div,
  input  logic              d_md_access,
  output logic              stall,
  output logic              pc_en,
  output logic              d_reg_en,
  output logic              e_reg_clr,
  output logic [FSEL_W-1:0] fwd_rs_sel,
  output logic [FSEL_W-1:0] fwd_rt_sel,
  output logic              md_busy
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int MDC_W   = $clog2(MAX_LAT + 1);
  localparam logic [TNEW_W-1:0] TUSE_NONE = '1;

  // Stage k of the tracker holds the destination and remaining Tnew of the
  // instruction currently in post-D stage k (1 = E). Address 0 means "no write".
  logic [NSTAGE:1][4:0]        addr_q, addr_d;
  logic [NSTAGE:1][TNEW_W-1:0] tnew_q, tnew_d;
  logic [MDC_W-1:0]            md_cnt_q, md_cnt_d;

  logic              rs_hit, rt_hit;
  logic [FSEL_W-1:0] rs_stage, rt_stage;
  logic [TNEW_W-1:0] rs_tnew, rt_tnew;
  logic              data_stall, md_stall;

  // Nearest-stage lookup for rs; scanning from the oldest stage lets the youngest match win.
  always_comb begin
    rs_hit   = 1'b0;
    rs_stage = '0;
    rs_tnew  = '0;
    if (d_rs != 5'd0 && d_tuse_rs != TUSE_NONE) begin
      for (int k = NSTAGE; k >= 1; k--) begin
        if (addr_q[k] == d_rs) begin
          rs_hit   = 1'b1;
          rs_stage = FSEL_W'(k);
          rs_tnew  = tnew_q[k];
        end
      end
    end
  end

  // Nearest-stage lookup for rt, same shadowing rule as rs.
  always_comb begin
    rt_hit   = 1'b0;
    rt_stage = '0;
    rt_tnew  = '0;
    if (d_rt != 5'd0 && d_tuse_rt != TUSE_NONE) begin
      for (int k = NSTAGE; k >= 1; k--) begin
        if (addr_q[k] == d_rt) begin
          rt_hit   = 1'b1;
          rt_stage = FSEL_W'(k);
          rt_tnew  = tnew_q[k];
        end
      end
    end
  end

  // Stall and forward decisions; a pending producer forwards nothing so later stages re-resolve.
  always_comb begin
    data_stall = (rs_hit && (rs_tnew > d_tuse_rs)) || (rt_hit && (rt_tnew > d_tuse_rt));
    md_busy    = (md_cnt_q != '0);
    md_stall   = md_busy && (d_md_start || d_md_access);
    stall      = data_stall || md_stall;
    pc_en      = ~stall;
    d_reg_en   = ~stall;
    e_reg_clr  = stall;
    fwd_rs_sel = (rs_hit && rs_tnew == '0) ? rs_stage : '0;
    fwd_rt_sel = (rt_hit && rt_tnew == '0) ? rt_stage : '0;
  end

  // Next state: shift the tracker one stage, ageing Tnew; a stall injects a bubble into E.
  always_comb begin
    addr_d = addr_q;
    tnew_d = tnew_q;
    addr_d[1] = stall ? 5'd0 : d_wr_addr;
    tnew_d[1] = stall ? '0 : d_tnew;
    for (int k = 2; k <= NSTAGE; k++) begin
      addr_d[k] = addr_q[k-1];
      tnew_d[k] = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - 1'b1;
    end
    if (!stall && d_md_start) begin
      md_cnt_d = d_md_is_div ? MDC_W'(DIV_LAT) : MDC_W'(MULT_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end else begin
      md_cnt_d = '0;
    end
  end

  // State registers; reset clears the tracker and aborts any MDU operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      tnew_q   <= '0;
      md_cnt_q <= '0;
    end else begin
      addr_q   <= addr_d;
      tnew_q   <= tnew_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus a randomized run
// checked against a timeline model (writers tracked by the cycle they entered E).
module tb_hazard_scoreboard;

  localparam int NSTAGE    = 3;
  localparam int MULT_LAT  = 5;
  localparam int DIV_LAT   = 10;
  localparam int TUSE_NONE = 7;

  logic       clk;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_wr_addr;
  logic [2:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_start, d_md_is_div, d_md_access;
  logic       stall, pc_en, d_reg_en, e_reg_clr, md_busy;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  int vectors = 0;
  int errors  = 0;

  hazard_scoreboard #(.NSTAGE(NSTAGE), .TNEW_W(3), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wr_addr(d_wr_addr), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_is_div(d_md_is_div), .d_md_access(d_md_access),
    .stall(stall), .pc_en(pc_en), .d_reg_en(d_reg_en), .e_reg_clr(e_reg_clr),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct { int addr; int tnew; int cyc; } wr_t;
  wr_t hist[$];
  int  cur    = 0;
  int  md_end = 0;

  function automatic void lookup(input int s, input int tuse, output int st, output int rem);
    st  = 0;
    rem = 0;
    if (s == 0 || tuse == TUSE_NONE) return;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      int stage;
      stage = cur - hist[i].cyc + 1;
      if (hist[i].addr == s && stage >= 1 && stage <= NSTAGE) begin
        st  = stage;
        rem = hist[i].tnew - (stage - 1);
        if (rem < 0) rem = 0;
        return;
      end
    end
  endfunction

  task automatic model_eval(output logic e_stall, output logic [1:0] e_frs,
                            output logic [1:0] e_frt, output logic e_busy);
    int st_s, rem_s, st_t, rem_t;
    logic ds;
    lookup(int'(d_rs), int'(d_tuse_rs), st_s, rem_s);
    lookup(int'(d_rt), int'(d_tuse_rt), st_t, rem_t);
    ds = (st_s != 0 && rem_s > int'(d_tuse_rs)) || (st_t != 0 && rem_t > int'(d_tuse_rt));
    e_busy  = (cur < md_end);
    e_stall = ds || (e_busy && (d_md_start || d_md_access));
    e_frs   = (st_s != 0 && rem_s == 0) ? 2'(st_s) : 2'd0;
    e_frt   = (st_t != 0 && rem_t == 0) ? 2'(st_t) : 2'd0;
  endtask

  task automatic model_commit(input logic rst, input logic st);
    if (rst) begin
      hist.delete();
      md_end = 0;
    end else if (!st) begin
      if (d_wr_addr != 5'd0) hist.push_back('{int'(d_wr_addr), int'(d_tnew), cur + 1});
      if (d_md_start) md_end = cur + 1 + (d_md_is_div ? DIV_LAT : MULT_LAT);
    end
    cur++;
    while (hist.size() > 0 && (cur - hist[0].cyc + 1) > NSTAGE) void'(hist.pop_front());
  endtask

  // Advance one clock, keeping the model in step; returns just after the edge.
  task automatic tick();
    logic s, b;
    logic [1:0] a, c;
    model_eval(s, a, c, b);
    @(posedge clk);
    model_commit(reset, s);
    #1;
  endtask

  task automatic idle();
    d_rs = 0; d_rt = 0; d_tuse_rs = 3'd7; d_tuse_rt = 3'd7;
    d_wr_addr = 0; d_tnew = 0;
    d_md_start = 0; d_md_is_div = 0; d_md_access = 0;
  endtask

  task automatic flush();
    idle();
    repeat (NSTAGE + 1) tick();
  endtask

  // ---------------- directed tests ----------------
  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0 || pc_en !== 1'b1 || d_reg_en !== 1'b1 || e_reg_clr !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got stall=%b pc_en=%b d_reg_en=%b e_reg_clr=%b, expected 0 1 1 0",
               stall, pc_en, d_reg_en, e_reg_clr);
    end
    vectors++;
    if (fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0 || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_fwd: got rs=%0d rt=%0d busy=%b, expected 0 0 0", fwd_rs_sel, fwd_rt_sel, md_busy);
    end
    tick();
  endtask

  task automatic test_load_use();
    idle(); d_wr_addr = 5'd1; d_tnew = 3'd2;
    tick();
    idle(); d_rs = 5'd1; d_tuse_rs = 3'd1; d_wr_addr = 5'd2; d_tnew = 3'd1;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b1 || e_reg_clr !== 1'b1 || pc_en !== 1'b0 || d_reg_en !== 1'b0) begin
      errors++;
      $display("FAIL load_use_stall: got stall=%b clr=%b pc_en=%b den=%b, expected 1 1 0 0",
               stall, e_reg_clr, pc_en, d_reg_en);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0 || fwd_rs_sel !== 2'd0) begin
      errors++;
      $display("FAIL load_use_release: got stall=%b fwd_rs=%0d, expected 0 0", stall, fwd_rs_sel);
    end
    tick();
    flush();
  endtask

  task automatic test_branch_fwd();
    idle(); d_wr_addr = 5'd3; d_tnew = 3'd1;
    tick();
    idle(); d_rs = 5'd3; d_tuse_rs = 3'd0;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL branch_stall: got %b expected 1", stall);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0 || fwd_rs_sel !== 2'd2) begin
      errors++;
      $display("FAIL branch_fwd: got stall=%b fwd_rs=%0d, expected 0 2", stall, fwd_rs_sel);
    end
    tick();
    flush();
  endtask

  task automatic test_mdu_busy();
    idle(); d_md_start = 1'b1; d_md_is_div = 1'b0;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0 || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL mult_issue: got stall=%b busy=%b, expected 0 0", stall, md_busy);
    end
    tick();
    idle(); d_md_access = 1'b1;
    for (int i = 0; i < MULT_LAT; i++) begin
      @(negedge clk);
      vectors++;
      if (stall !== 1'b1 || md_busy !== 1'b1) begin
        errors++;
        $display("FAIL mfhi_wait cycle %0d: got stall=%b busy=%b, expected 1 1", i, stall, md_busy);
      end
      tick();
    end
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0 || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL mfhi_issue: got stall=%b busy=%b, expected 0 0", stall, md_busy);
    end
    tick();
    flush();
  endtask

  task automatic test_reg_zero();
    idle(); d_wr_addr = 5'd0; d_tnew = 3'd2;
    tick();
    idle(); d_rs = 5'd0; d_tuse_rs = 3'd0; d_rt = 5'd0; d_tuse_rt = 3'd0;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0 || fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin
      errors++;
      $display("FAIL reg_zero: got stall=%b rs=%0d rt=%0d, expected 0 0 0", stall, fwd_rs_sel, fwd_rt_sel);
    end
    tick();
    flush();
  endtask

  task automatic test_back_to_back();
    idle(); d_wr_addr = 5'd5; d_tnew = 3'd0;
    tick();
    tick();
    idle(); d_rs = 5'd5; d_tuse_rs = 3'd0; d_rt = 5'd5; d_tuse_rt = 3'd1;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0 || fwd_rs_sel !== 2'd1 || fwd_rt_sel !== 2'd1) begin
      errors++;
      $display("FAIL nearest_wins: got stall=%b rs=%0d rt=%0d, expected 0 1 1", stall, fwd_rs_sel, fwd_rt_sel);
    end
    tick();
    flush();
  endtask

  task automatic test_reset_mid_div();
    idle(); d_md_start = 1'b1; d_md_is_div = 1'b1; d_wr_addr = 5'd7; d_tnew = 3'd0;
    tick();
    idle();
    tick();
    tick();
    d_md_access = 1'b1;
    @(negedge clk);
    vectors++;
    if (md_busy !== 1'b1 || stall !== 1'b1) begin
      errors++;
      $display("FAIL div_running: got busy=%b stall=%b, expected 1 1", md_busy, stall);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    d_rs = 5'd7; d_tuse_rs = 3'd0; d_rt = 5'd7; d_tuse_rt = 3'd0;
    @(negedge clk);
    vectors++;
    if (md_busy !== 1'b0 || stall !== 1'b0 || fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_div: got busy=%b stall=%b rs=%0d rt=%0d, expected 0 0 0 0",
               md_busy, stall, fwd_rs_sel, fwd_rt_sel);
    end
    tick();
    flush();
  endtask

  // ---------------- randomized run against the model ----------------
  task automatic test_random();
    logic e_stall, e_busy;
    logic [1:0] e_frs, e_frt;
    for (int n = 0; n < 600; n++) begin
      d_rs        = 5'($urandom_range(0, 3));
      d_rt        = 5'($urandom_range(0, 3));
      d_tuse_rs   = ($urandom_range(0, 5) == 0) ? 3'd7 : 3'($urandom_range(0, 3));
      d_tuse_rt   = ($urandom_range(0, 5) == 0) ? 3'd7 : 3'($urandom_range(0, 3));
      d_wr_addr   = 5'($urandom_range(0, 3));
      d_tnew      = 3'($urandom_range(0, 3));
      d_md_start  = ($urandom_range(0, 9) == 0);
      d_md_is_div = 1'($urandom_range(0, 1));
      d_md_access = ($urandom_range(0, 7) == 0);
      reset       = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      model_eval(e_stall, e_frs, e_frt, e_busy);
      vectors++;
      if (stall !== e_stall || pc_en !== ~e_stall || d_reg_en !== ~e_stall || e_reg_clr !== e_stall) begin
        errors++;
        $display("FAIL rand_stall n=%0d: got stall=%b pc_en=%b den=%b clr=%b, expected stall=%b",
                 n, stall, pc_en, d_reg_en, e_reg_clr, e_stall);
      end
      vectors++;
      if (fwd_rs_sel !== e_frs || fwd_rt_sel !== e_frt) begin
        errors++;
        $display("FAIL rand_fwd n=%0d: got rs=%0d rt=%0d, expected rs=%0d rt=%0d",
                 n, fwd_rs_sel, fwd_rt_sel, e_frs, e_frt);
      end
      vectors++;
      if (md_busy !== e_busy) begin
        errors++;
        $display("FAIL rand_busy n=%0d: got %b expected %b", n, md_busy, e_busy);
      end
      tick();
    end
    reset = 1'b0;
    flush();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #1;
    test_reset();
    test_load_use();
    test_branch_fwd();
    test_mdu_busy();
    test_reg_zero();
    test_back_to_back();
    test_reset_mid_div();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
